// File: rtl/mano_seq_pkg.sv
// Shared types and constants for the parametrised Mano control sequencer:
// state encoding, ctrl strobe bit map and the per-opcode last-T lookup.
package mano_seq_pkg;

    typedef enum logic [3:0] {
        IDLE_T0, FETCH_RD, DECODE, INDIR_RD, EXEC, INT0, INT1, INT2, HALT
    } seq_state_e;

    localparam int CTRL_W     = 9;
    localparam int LD_AR_PC   = 0;
    localparam int MEM_RD     = 1;
    localparam int LD_IR      = 2;
    localparam int INR_PC     = 3;
    localparam int LD_AR_MEM  = 4;
    localparam int CLR_AR_VEC = 5;
    localparam int LD_TR_PC   = 6;
    localparam int MEM_WR     = 7;
    localparam int PC_VEC     = 8;

    // Register-reference / IO opcode (D7).
    localparam int OPC_IO = 7;

    // Final T step of each opcode; -1 marks an undefined opcode that never
    // retires on its own and is left to the watchdog.
    function automatic int last_t(input int opc);
        case (opc)
            0, 1, 2, 5: last_t = 5;
            3, 4:       last_t = 4;
            6:          last_t = 6;
            7:          last_t = 3;
            default:    last_t = -1;
        endcase
    endfunction

endpackage

// File: rtl/mano_seq_if.sv
// Bundle between the sequencer and its IR/flag sources and micro-op decoders.
interface mano_seq_if #(
    parameter int DATA_W = 16,
    parameter int OPC_W  = 3,
    parameter int SC_W   = 4
) ();
    logic [DATA_W-1:0]               ir_q;
    logic                            mem_ack;
    logic                            fgi;
    logic                            fgo;
    logic [SC_W-1:0]                 sc_q;
    logic [2**SC_W-1:0]              t_oh;
    logic [2**OPC_W-1:0]             d_oh;
    logic                            i_bit;
    logic                            r_flag;
    logic                            ien;
    logic                            halted;
    logic                            seq_err;
    logic [mano_seq_pkg::CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0]               vec_addr;

    modport master (
        input  ir_q, mem_ack, fgi, fgo,
        output sc_q, t_oh, d_oh, i_bit, r_flag, ien, halted, seq_err, ctrl, vec_addr
    );

    modport slave (
        output ir_q, mem_ack, fgi, fgo,
        input  sc_q, t_oh, d_oh, i_bit, r_flag, ien, halted, seq_err, ctrl, vec_addr
    );
endinterface

// File: rtl/mano_seq_counter.sv
// Sequence counter with clear/stall/freeze and its one-hot T decode.
module mano_seq_counter #(
    parameter int SC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    input  logic               stall,
    input  logic               freeze,
    output logic [SC_W-1:0]    sc_q,
    output logic [2**SC_W-1:0] t_oh
);
    logic [SC_W-1:0] sc_reg, sc_next;

    always_comb begin
        sc_next = sc_reg;
        if (clr)
            sc_next = '0;
        else if (inc && !stall && !freeze)
            sc_next = sc_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sc_reg <= '0;
        else
            sc_reg <= sc_next;
    end

    assign sc_q = sc_reg;

    for (genvar gi = 0; gi < 2**SC_W; gi++) begin : g_t_dec
        assign t_oh[gi] = (sc_reg == SC_W'(gi));
    end
endmodule

// File: rtl/mano_sequencer_p.sv
// Mano control sequencer with memory handshake, interrupt cycle and watchdog.
// Optional SEQ_SINGLE_STEP_EN adds step_en/step to gate each instruction at T0.
module mano_sequencer_p
    import mano_seq_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int OPC_W    = 3,
    parameter int SC_W     = 4,
    parameter int INTR_VEC = 0
) (
    input logic        clk,
    input logic        CLR_GLOBAL,
`ifdef SEQ_SINGLE_STEP_EN
    input logic        step_en,
    input logic        step,
`endif
    mano_seq_if.master bus
);
    localparam logic [SC_W-1:0] SC_MAX = '1;

    seq_state_e          state_reg, state_next;
    logic [OPC_W-1:0]    opc_reg, opc_next;
    logic                i_reg, i_next, dv_reg, dv_next;
    logic                r_reg, r_next, ien_reg, ien_next, halted_reg, halted_next;
    logic [CTRL_W-1:0]   ctrl_v;
    logic                sc_clr, sc_stall, sc_freeze, mem_busy, clr_evt, iof, wd_hit;
    logic                go, t0_go;
    logic [SC_W-1:0]     sc_q;
    logic [2**SC_W-1:0]  t_oh;
    logic [2**OPC_W-1:0] d_oh;
    logic [OPC_W-1:0]    opc_ir;
    logic                i_ir;
    logic                unused_sig;

    assign opc_ir     = bus.ir_q[DATA_W-2 -: OPC_W];
    assign i_ir       = bus.ir_q[DATA_W-1];
    assign unused_sig = ^{bus.ir_q, t0_go};

`ifdef SEQ_SINGLE_STEP_EN
    logic step_pend_reg;
    assign go = !step_en || step || step_pend_reg;
    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL)
            step_pend_reg <= 1'b0;
        else
            step_pend_reg <= (step_pend_reg || step) && !t0_go;
    end
`else
    assign go = 1'b1;
`endif

    always_comb begin
        state_next  = state_reg;
        opc_next    = opc_reg;
        i_next      = i_reg;
        dv_next     = dv_reg;
        r_next      = r_reg;
        ien_next    = ien_reg;
        halted_next = halted_reg;
        ctrl_v      = '0;
        sc_clr      = 1'b0;
        sc_freeze   = 1'b0;
        mem_busy    = 1'b0;
        clr_evt     = 1'b0;
        iof         = 1'b0;
        wd_hit      = 1'b0;
        t0_go       = 1'b0;
        case (state_reg)
            IDLE_T0: begin
                if (go) begin
                    ctrl_v[LD_AR_PC] = 1'b1;
                    t0_go            = 1'b1;
                    state_next       = FETCH_RD;
                end else begin
                    sc_freeze = 1'b1;
                end
            end
            FETCH_RD: begin
                ctrl_v[MEM_RD] = 1'b1;
                mem_busy       = 1'b1;
                if (bus.mem_ack) begin
                    ctrl_v[LD_IR]  = 1'b1;
                    ctrl_v[INR_PC] = 1'b1;
                    state_next     = DECODE;
                end
            end
            DECODE: begin
                opc_next   = opc_ir;
                i_next     = i_ir;
                dv_next    = 1'b1;
                state_next = (int'(opc_ir) != OPC_IO && i_ir) ? INDIR_RD : EXEC;
            end
            INDIR_RD: begin
                ctrl_v[MEM_RD] = 1'b1;
                mem_busy       = 1'b1;
                if (bus.mem_ack) begin
                    ctrl_v[LD_AR_MEM] = 1'b1;
                    state_next        = EXEC;
                end
            end
            EXEC: begin
                if (int'(sc_q) == last_t(int'(opc_reg))) begin
                    clr_evt    = 1'b1;
                    sc_clr     = 1'b1;
                    state_next = IDLE_T0;
                    if (int'(opc_reg) == OPC_IO) begin
                        if (!i_reg && bus.ir_q[0]) begin
                            halted_next = 1'b1;
                            state_next  = HALT;
                        end
                        if (i_reg && bus.ir_q[7])
                            ien_next = 1'b1;
                        if (i_reg && bus.ir_q[6]) begin
                            ien_next = 1'b0;
                            iof      = 1'b1;
                        end
                    end
                end
            end
            INT0: begin
                if (go) begin
                    ctrl_v[CLR_AR_VEC] = 1'b1;
                    ctrl_v[LD_TR_PC]   = 1'b1;
                    t0_go              = 1'b1;
                    state_next         = INT1;
                end else begin
                    sc_freeze = 1'b1;
                end
            end
            INT1: begin
                ctrl_v[MEM_WR] = 1'b1;
                mem_busy       = 1'b1;
                if (bus.mem_ack) begin
                    ctrl_v[PC_VEC] = 1'b1;
                    state_next     = INT2;
                end
            end
            INT2: begin
                ctrl_v[INR_PC] = 1'b1;
                ien_next       = 1'b0;
                r_next         = 1'b0;
                sc_clr         = 1'b1;
                state_next     = IDLE_T0;
            end
            HALT:    sc_freeze = 1'b1;
            default: begin
                sc_clr     = 1'b1;
                state_next = IDLE_T0;
            end
        endcase

        sc_stall = mem_busy && !bus.mem_ack;

        // Interrupt request is sampled on the retiring cycle so T0 goes straight to INT0.
        if (clr_evt) begin
            if (ien_reg && (bus.fgi || bus.fgo) && !iof)
                r_next = 1'b1;
            if (r_next && state_next == IDLE_T0)
                state_next = INT0;
        end

        if (sc_q == SC_MAX && !sc_clr) begin
            wd_hit     = 1'b1;
            sc_clr     = 1'b1;
            sc_stall   = 1'b0;
            r_next     = 1'b0;
            ctrl_v     = '0;
            state_next = IDLE_T0;
        end
    end

    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL) begin
            state_reg  <= IDLE_T0;
            opc_reg    <= '0;
            i_reg      <= 1'b0;
            dv_reg     <= 1'b0;
            r_reg      <= 1'b0;
            ien_reg    <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            opc_reg    <= opc_next;
            i_reg      <= i_next;
            dv_reg     <= dv_next;
            r_reg      <= r_next;
            ien_reg    <= ien_next;
            halted_reg <= halted_next;
        end
    end

    mano_seq_counter #(.SC_W(SC_W)) u_counter (
        .clk    (clk),
        .rst    (CLR_GLOBAL),
        .inc    (1'b1),
        .clr    (sc_clr),
        .stall  (sc_stall),
        .freeze (sc_freeze),
        .sc_q   (sc_q),
        .t_oh   (t_oh)
    );

    // During T2 the decode follows IR live; afterwards it holds the latched opcode.
    for (genvar gi = 0; gi < 2**OPC_W; gi++) begin : g_d_dec
        assign d_oh[gi] = (state_reg == DECODE) ? (opc_ir == OPC_W'(gi))
                                                : (dv_reg && opc_reg == OPC_W'(gi));
    end

    assign bus.sc_q     = sc_q;
    assign bus.t_oh     = t_oh;
    assign bus.d_oh     = d_oh;
    assign bus.i_bit    = (state_reg == DECODE) ? i_ir : i_reg;
    assign bus.r_flag   = r_reg;
    assign bus.ien      = ien_reg;
    assign bus.halted   = halted_reg;
    assign bus.seq_err  = wd_hit;
    assign bus.ctrl     = CLR_GLOBAL ? '0 : ctrl_v;
    assign bus.vec_addr = DATA_W'(INTR_VEC);
endmodule

// File: tb/tb_mano_sequencer_p.sv
// Directed bench: instruction vector table plus hand sequences for HLT,
// reset during a stall and the watchdog (second instance with OPC_W=4).
module tb_mano_sequencer_p;
    import mano_seq_pkg::*;

    logic clk = 1'b0;
    logic rst, rst2;
    always #5 clk = ~clk;

    mano_seq_if #(.DATA_W(16), .OPC_W(3), .SC_W(4)) bus  ();
    mano_seq_if #(.DATA_W(16), .OPC_W(4), .SC_W(4)) bus2 ();

    mano_sequencer_p #(.DATA_W(16), .OPC_W(3), .SC_W(4), .INTR_VEC(0)) dut (
        .clk(clk), .CLR_GLOBAL(rst), .bus(bus)
    );
    mano_sequencer_p #(.DATA_W(16), .OPC_W(4), .SC_W(4), .INTR_VEC(0)) dut2 (
        .clk(clk), .CLR_GLOBAL(rst2), .bus(bus2)
    );

    localparam logic [8:0] C_T0   = 9'h001;            // LD_AR_PC
    localparam logic [8:0] C_INT0 = 9'h060;            // CLR_AR_VEC | LD_TR_PC
    localparam logic [8:0] C_RD   = 9'h002;            // MEM_RD alone

    typedef struct {
        logic [15:0] ir;
        int          stall;
        logic        fg;
        int          cyc;
        logic [7:0]  d;
        logic        chk_d;
        logic        i;
        logic [8:0]  c0;
        logic        ien;
        logic        r;
    } vec_t;

    vec_t tbl[15];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [15:0] ir, input int stall, input logic fg,
                                input int cyc, input logic [7:0] d, input logic chk_d,
                                input logic i, input logic [8:0] c0, input logic ien,
                                input logic r);
        vec_t v;
        v.ir = ir; v.stall = stall; v.fg = fg; v.cyc = cyc; v.d = d; v.chk_d = chk_d;
        v.i = i; v.c0 = c0; v.ien = ien; v.r = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs from a T0 negedge until SC is back at 0; stalls T1 for 'stall' cycles.
    task automatic run_instr(input logic [15:0] ir, input int stall, input logic fg,
                             output int cyc, output logic [31:0] d_seen, output logic i_seen,
                             output logic [31:0] c0, output logic stall_ok,
                             output logic err_seen);
        int st;
        st = stall; cyc = 0; stall_ok = 1'b1; err_seen = 1'b0; d_seen = '0; i_seen = 1'b0;
        bus.ir_q = ir; bus.fgi = fg; bus.mem_ack = 1'b1;
        #1;
        c0 = 32'(bus.ctrl);
        do begin
            if (bus.sc_q == 4'd1 && st > 0) begin
                bus.mem_ack = 1'b0;
                st--;
                #1;
                if (bus.ctrl !== C_RD) stall_ok = 1'b0;
            end else begin
                bus.mem_ack = 1'b1;
            end
            if (bus.seq_err) err_seen = 1'b1;
            if (bus.sc_q == 4'd3) begin
                d_seen = 32'(bus.d_oh);
                i_seen = bus.i_bit;
            end
            @(negedge clk);
            cyc++;
        end while (bus.sc_q != 4'd0 && cyc < 60);
        bus.mem_ack = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc, bad_h, wd_cyc;
        logic [31:0] d_seen, c0, wd_sc;
        logic        i_seen, stall_ok, err_seen, found;

        tbl[0]  = mk(16'h2005,  0, 0,  6, 8'h04, 1, 0, C_T0,   0, 0); // LDA
        tbl[1]  = mk(16'h2005,  3, 0,  9, 8'h04, 1, 0, C_T0,   0, 0); // LDA, 3 wait states
        tbl[2]  = mk(16'h9010,  0, 0,  6, 8'h02, 1, 1, C_T0,   0, 0); // ADD indirect
        tbl[3]  = mk(16'h3000,  0, 0,  5, 8'h08, 1, 0, C_T0,   0, 0); // STA
        tbl[4]  = mk(16'h6000,  0, 0,  7, 8'h40, 1, 0, C_T0,   0, 0); // ISZ
        tbl[5]  = mk(16'h4000,  0, 0,  5, 8'h10, 1, 0, C_T0,   0, 0); // BUN
        tbl[6]  = mk(16'h5000,  0, 0,  6, 8'h20, 1, 0, C_T0,   0, 0); // BSA
        tbl[7]  = mk(16'h0000, 15, 0, 21, 8'h01, 1, 0, C_T0,   0, 0); // AND, 15 wait states
        tbl[8]  = mk(16'h7800,  0, 0,  4, 8'h80, 1, 0, C_T0,   0, 0); // CLA
        tbl[9]  = mk(16'hF080,  0, 1,  4, 8'h80, 1, 1, C_T0,   1, 0); // ION
        tbl[10] = mk(16'h2005,  0, 1,  6, 8'h04, 1, 0, C_T0,   1, 1); // LDA, interrupt pending
        tbl[11] = mk(16'h0000,  0, 1,  3, 8'h00, 0, 0, C_INT0, 0, 0); // interrupt cycle
        tbl[12] = mk(16'hF080,  0, 1,  4, 8'h80, 1, 1, C_T0,   1, 0); // ION again
        tbl[13] = mk(16'hF040,  0, 1,  4, 8'h80, 1, 1, C_T0,   0, 0); // IOF: no request
        tbl[14] = mk(16'h2005,  0, 1,  6, 8'h04, 1, 0, C_T0,   0, 0); // ien off

        rst = 1'b1; rst2 = 1'b1;
        bus.ir_q = '0; bus.mem_ack = 1'b1; bus.fgi = 1'b0; bus.fgo = 1'b0;
        bus2.ir_q = 16'h4000; bus2.mem_ack = 1'b1; bus2.fgi = 1'b0; bus2.fgo = 1'b0;

        #2;
        check("rst_sc_q",    32'(bus.sc_q),    0);
        check("rst_t_oh",    32'(bus.t_oh),    1);
        check("rst_d_oh",    32'(bus.d_oh),    0);
        check("rst_i_bit",   32'(bus.i_bit),   0);
        check("rst_r_flag",  32'(bus.r_flag),  0);
        check("rst_ien",     32'(bus.ien),     0);
        check("rst_halted",  32'(bus.halted),  0);
        check("rst_seq_err", 32'(bus.seq_err), 0);
        check("rst_ctrl",    32'(bus.ctrl),    0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 15; k++) begin
            run_instr(tbl[k].ir, tbl[k].stall, tbl[k].fg, cyc, d_seen, i_seen, c0, stall_ok, err_seen);
            $display("row %0d ir=%h cycles=%0d d_oh=%h i=%b ien=%b r_flag=%b",
                     k, tbl[k].ir, cyc, d_seen, i_seen, bus.ien, bus.r_flag);
            check($sformatf("row%0d_cycles", k), 32'(cyc), 32'(tbl[k].cyc));
            if (tbl[k].chk_d) begin
                check($sformatf("row%0d_d_oh", k),  d_seen, 32'(tbl[k].d));
                check($sformatf("row%0d_i_bit", k), 32'(i_seen), 32'(tbl[k].i));
            end
            check($sformatf("row%0d_ctrl_t0", k),  c0, 32'(tbl[k].c0));
            check($sformatf("row%0d_ien", k),      32'(bus.ien), 32'(tbl[k].ien));
            check($sformatf("row%0d_r_flag", k),   32'(bus.r_flag), 32'(tbl[k].r));
            check($sformatf("row%0d_stall_ctrl", k), 32'(stall_ok), 1);
            check($sformatf("row%0d_seq_err", k),  32'(err_seen), 0);
        end
        bus.fgi = 1'b0;

        // HLT freezes SC at 0 until reset.
        run_instr(16'h7001, 0, 0, cyc, d_seen, i_seen, c0, stall_ok, err_seen);
        $display("hlt cycles=%0d halted=%b", cyc, bus.halted);
        check("hlt_cycles", 32'(cyc), 4);
        check("hlt_halted", 32'(bus.halted), 1);
        bad_h = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.sc_q != 4'd0 || bus.ctrl != 9'd0) bad_h++;
        end
        check("hlt_frozen", 32'(bad_h), 0);
        check("hlt_t_oh", 32'(bus.t_oh), 1);
        rst = 1'b1;
        #1;
        check("hlt_cleared", 32'(bus.halted), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a T1 stall drops the strobe without a clock edge.
        bus.ir_q = 16'h2005; bus.mem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("stall_sc_q", 32'(bus.sc_q), 1);
        check("stall_ctrl", 32'(bus.ctrl), 32'(C_RD));
        #2;
        rst = 1'b1;
        #1;
        $display("reset mid-stall ctrl=%h sc_q=%0d", bus.ctrl, bus.sc_q);
        check("rst_stall_ctrl", 32'(bus.ctrl), 0);
        check("rst_stall_sc_q", 32'(bus.sc_q), 0);
        @(negedge clk);
        rst = 1'b0; bus.mem_ack = 1'b1;

        // Undefined opcode on the OPC_W=4 instance runs until the watchdog fires.
        rst2 = 1'b0;
        found = 1'b0; wd_cyc = -1; wd_sc = '1;
        for (int c = 0; c < 40 && !found; c++) begin
            if (bus2.seq_err) begin
                found = 1'b1; wd_cyc = c; wd_sc = 32'(bus2.sc_q);
            end else begin
                @(negedge clk);
            end
        end
        $display("watchdog seen=%b cycle=%0d sc_q=%0d", found, wd_cyc, wd_sc);
        check("wd_seen", 32'(found), 1);
        check("wd_sc_q", wd_sc, 15);
        check("wd_cycle", 32'(wd_cyc), 15);
        @(negedge clk);
        check("wd_sc_after", 32'(bus2.sc_q), 0);
        check("wd_pulse_end", 32'(bus2.seq_err), 0);
        check("wd_r_flag", 32'(bus2.r_flag), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mano_sequencer_p.md
Name: mano_sequencer_p

Overview:
- Parametrised successor to the team's fixed 16-bit Mano control sequencer.
- Owns the sequence counter, the T/D one-hot decode, the I and R flags, the IEN flip-flop and halt.
- Adds a memory ready/ack handshake with wait states, per-opcode instruction-length retirement, an overrun watchdog, and an interrupt-cycle FSM.
- Sits between IR/flag sources and the downstream register/ALU micro-op decoders, which consume t_oh/d_oh/r_flag.

Parameters:
- DATA_W, 16, instruction/data word width; opcode is [DATA_W-2 -: OPC_W], I is bit DATA_W-1.
- OPC_W, 3, opcode width; D one-hot is 2**OPC_W wide.
- SC_W, 4, sequence counter width; T one-hot is 2**SC_W wide.
- INTR_VEC, 0, PC/AR value forced during the interrupt cycle.

Ports:
- clk, input, 1, system clock, rising edge.
- CLR_GLOBAL, input, 1, asynchronous active-high reset.
- ir_q, input, DATA_W, current IR contents.
- mem_ack, input, 1, memory completes the current mem_rd/mem_wr this cycle.
- fgi, input, 1, input flag.
- fgo, input, 1, output flag.
- sc_q, output, SC_W, sequence counter.
- t_oh, output, 2**SC_W, one-hot of sc_q.
- d_oh, output, 2**OPC_W, one-hot opcode, valid from T2.
- i_bit, output, 1, latched indirect bit.
- r_flag, output, 1, interrupt-cycle flag.
- ien, output, 1, interrupt enable.
- halted, output, 1, HLT executed.
- seq_err, output, 1, one-cycle pulse on watchdog overrun.
- ctrl, output, CTRL_W, fetch/indirect/interrupt strobes (bit map in package).

Behaviour:
- Reset: sc_q=0, t_oh=1, d_oh=0, i_bit=0, r_flag=0, ien=0, halted=0, seq_err=0, ctrl=0.
- States: IDLE_T0, FETCH_RD, DECODE, INDIR_RD, EXEC, INT0, INT1, INT2, HALT.
- SC advance rule: sc_q increments each cycle except:
  - while a memory strobe is asserted and mem_ack=0 (stall; strobe held stable);
  - when cleared.
- Fetch sequence:
  - T0: LD_AR_PC.
  - T1: MEM_RD + LD_IR + INR_PC; completes on mem_ack.
  - T2: latch d_oh and i_bit from ir_q.
  - Exception: at T0, if r_flag=1, enter INT0 instead of fetching.
- T3 with D7=0 and I=1: MEM_RD + LD_AR_MEM (indirect), stall rules apply.
- EXEC: SC clears after the cycle given by package table LAST_T[opcode]: AND/ADD/LDA/BSA=5, STA/BUN=4, ISZ=6. Register-ref and IO (D7) clear at T3.
- Register-ref with IR[0]=1 (HLT): halted=1, SC frozen at 0. Only CLR_GLOBAL exits.
- IO decode (D7 & I):
  - IR[7] sets ien at end of T3.
  - IR[6] clears ien at end of T3.
- r_flag set condition: on any cycle where SC clears, if ien & (fgi|fgo) and the instruction did not execute IOF. Evaluated the same cycle, so the next T0 enters INT0.
- Interrupt cycle:
  - INT0: CLR_AR_VEC, LD_TR_PC.
  - INT1: MEM_WR + PC_VEC; stalls on mem_ack.
  - INT2: INR_PC; ien=0, r_flag=0, SC clears.
- Watchdog: if sc_q reaches 2**SC_W-1 without a clear, pulse seq_err, force SC=0 and r_flag=0. The instruction is abandoned.
- ctrl is purely combinational from state/sc_q/mem_ack. No strobe toggles during a stall.
- CLR_GLOBAL mid-stall: all outputs return to reset values immediately. The memory strobe drops asynchronously.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN adds input ports step_en and step.
- With step_en=1, the sequencer holds at T0 (no fetch strobes) until a step pulse, then runs exactly one instruction or interrupt cycle.
- With step_en=0, or with the macro undefined (ports absent), it runs freely.

Decomposition:
- Package mano_seq_pkg holds:
  - the state enum;
  - the CTRL_W constant and ctrl bit indices (LD_AR_PC, MEM_RD, LD_IR, INR_PC, LD_AR_MEM, CLR_AR_VEC, LD_TR_PC, MEM_WR, PC_VEC);
  - the LAST_T lookup function.
- Sub-module mano_seq_counter: SC register with inc/clr/stall/freeze and the one-hot decode.

Test Plan:
- Reset, then LDA direct (ir_q=16'h2005), mem_ack tied 1 → d_oh=8'h04; SC clears after T5; 6 cycles total.
- Same instruction with mem_ack low for 3 cycles at T1 → sc_q holds 1, MEM_RD stays high; completes at cycle 9.
- Indirect ADD (ir_q=16'h9010) → INDIR_RD at T3; clear after T5.
- ION (16'hF080), then fgi=1 → ien=1; r_flag=1 at the next SC clear; INT0..INT2 run; ien=0, r_flag=0 after INT2.
- HLT (16'h7001) → halted=1, sc_q frozen at 0 for 20 cycles; CLR_GLOBAL clears halted.
- Stall mem_ack low for 15 cycles from T1 with SC_W=4 → no seq_err. Force an undefined long EXEC path → seq_err pulse at sc_q=15, then SC=0.
